// File: rtl/axi4_mon_pkg.sv
// Shared definitions for the passive AXI4 slave-side protocol monitor.
// err_e values are bit positions inside err_status.
package axi4_mon_pkg;

  localparam int ERR_W  = 16;
  localparam int NUM_CH = 5;

  typedef enum logic [3:0] {
    ERR_AW_STABLE     = 4'd0,
    ERR_W_STABLE      = 4'd1,
    ERR_AR_STABLE     = 4'd2,
    ERR_R_STABLE      = 4'd3,
    ERR_B_STABLE      = 4'd4,
    ERR_AW_ALIGN      = 4'd5,
    ERR_AR_ALIGN      = 4'd6,
    ERR_W_LAST        = 4'd7,
    ERR_R_LAST        = 4'd8,
    ERR_W_NO_AW       = 4'd9,
    ERR_R_NO_AR       = 4'd10,
    ERR_B_EARLY       = 4'd11,
    ERR_TIMEOUT       = 4'd12,
    ERR_OVERFLOW      = 4'd13,
    ERR_BRESP_ILLEGAL = 4'd14,
    ERR_RRESP_ILLEGAL = 4'd15
  } err_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // This slave never returns EXOKAY or DECERR, so any odd response code is illegal.
  function automatic logic resp_illegal(input logic [1:0] resp);
    return resp[0];
  endfunction

endpackage

// File: rtl/axi4_burst_tracker.sv
// Outstanding-burst tracker: FIFO of burst lengths plus a beat counter for the head burst.
// Used once for the write side (AW/W) and once for the read side (AR/R).
module axi4_burst_tracker #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_len,
  input  logic       beat,
  input  logic       last,
  input  logic       probe,
  output logic       full,
  output logic       pop,
  output logic       last_err,
  output logic       no_cmd
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    len_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    beat_cnt;
  logic [7:0]    head_len;
  logic          empty;
  logic          bypass;
  logic          have_cmd;
  logic          at_end;
  logic          store;
  logic          deq;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign bypass   = empty && push;
  assign have_cmd = !empty || push;
  assign head_len = bypass ? push_len : len_q[rd_ptr];
  assign at_end   = (beat_cnt == head_len);

  // A beat that should have been last still pops, so one bad burst does not skew the next.
  assign pop      = beat && have_cmd && (last || at_end);
  assign last_err = beat && have_cmd && (last != at_end);
  assign no_cmd   = probe && !have_cmd;

  // A command bypassed and completed in the same cycle never enters storage.
  assign store = push && (!full || pop) && !(bypass && pop);
  assign deq   = pop && !empty;

  always_ff @(posedge clk) begin
    if (store) len_q[wr_ptr] <= push_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (deq)   rd_ptr <= rd_ptr + PW'(1);
      case ({store, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (beat && have_cmd) beat_cnt <= pop ? 8'd0 : beat_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 slave-side protocol monitor: sticky error bits, error interrupt and
// completion counters. Observes the bus only; drives nothing back onto it.
module axi4_protocol_monitor
  import axi4_mon_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic                    AWVALID,
  input  logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  input  logic                    RREADY,
  input  logic                    err_clr,
  output logic [ERR_W-1:0]        err_status,
  output logic                    err_irq,
  output logic [CNT_WIDTH-1:0]    wr_done_cnt,
  output logic [CNT_WIDTH-1:0]    rd_done_cnt
);

  localparam int W_PAYW = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int A_PAYW = ADDR_WIDTH + 11;
  localparam int PAYW   = (W_PAYW > A_PAYW) ? W_PAYW : A_PAYW;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic            wr_full, wr_pop, wr_last_err, wr_no_cmd;
  logic            rd_full, rd_pop, rd_last_err, rd_no_cmd;
  logic [7:0]      pend_b;
  logic [ERR_W-1:0] err_now;

  logic [PAYW-1:0]   ch_pay [NUM_CH];
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] stable_err;
  logic [NUM_CH-1:0] timeout_hit;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [2:0] size);
    return (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
  endfunction

  // Channel order matches the *_STABLE bit order: AW, W, AR, R, B.
  always_comb begin
    ch_pay[0] = PAYW'({AWADDR, AWLEN, AWSIZE});
    ch_pay[1] = PAYW'({WDATA, WSTRB, WLAST});
    ch_pay[2] = PAYW'({ARADDR, ARLEN, ARSIZE});
    ch_pay[3] = PAYW'({RDATA, RRESP, RLAST});
    ch_pay[4] = PAYW'(BRESP);
  end

  assign ch_valid = {BVALID, RVALID, ARVALID, WVALID, AWVALID};
  assign ch_ready = {BREADY, RREADY, ARREADY, WREADY, AWREADY};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic            prev_valid;
    logic            prev_ready;
    logic [PAYW-1:0] prev_pay;
    logic [TW-1:0]   stall_cnt;
    logic            stall;

    assign stall = ch_valid[c] && !ch_ready[c];

    always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
        prev_valid <= 1'b0;
        prev_ready <= 1'b0;
        prev_pay   <= '0;
        stall_cnt  <= '0;
      end else begin
        prev_valid <= ch_valid[c];
        prev_ready <= ch_ready[c];
        prev_pay   <= ch_pay[c];
        if (!stall)
          stall_cnt <= '0;
        else if (stall_cnt != TW'(TIMEOUT_CYCLES))
          stall_cnt <= stall_cnt + TW'(1);
      end
    end

    assign stable_err[c]  = prev_valid && !prev_ready &&
                            (!ch_valid[c] || (ch_pay[c] != prev_pay));
    assign timeout_hit[c] = stall && (stall_cnt >= TW'(TIMEOUT_CYCLES - 1));
  end

  axi4_burst_tracker #(.DEPTH(MAX_OUTSTANDING)) u_wr_trk (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (aw_hs),
    .push_len (AWLEN),
    .beat     (w_hs),
    .last     (WLAST),
    .probe    (w_hs),
    .full     (wr_full),
    .pop      (wr_pop),
    .last_err (wr_last_err),
    .no_cmd   (wr_no_cmd)
  );

  axi4_burst_tracker #(.DEPTH(MAX_OUTSTANDING)) u_rd_trk (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (ar_hs),
    .push_len (ARLEN),
    .beat     (r_hs),
    .last     (RLAST),
    .probe    (RVALID),
    .full     (rd_full),
    .pop      (rd_pop),
    .last_err (rd_last_err),
    .no_cmd   (rd_no_cmd)
  );

  always_comb begin
    err_now                    = '0;
    err_now[NUM_CH-1:0]        = stable_err;
    err_now[ERR_AW_ALIGN]      = aw_hs && ((AWADDR & size_mask(AWSIZE)) != '0);
    err_now[ERR_AR_ALIGN]      = ar_hs && ((ARADDR & size_mask(ARSIZE)) != '0);
    err_now[ERR_W_LAST]        = wr_last_err;
    err_now[ERR_R_LAST]        = rd_last_err;
    err_now[ERR_W_NO_AW]       = wr_no_cmd;
    err_now[ERR_R_NO_AR]       = rd_no_cmd;
    err_now[ERR_B_EARLY]       = BVALID && (pend_b == 8'd0);
    err_now[ERR_TIMEOUT]       = |timeout_hit;
    err_now[ERR_OVERFLOW]      = (aw_hs && wr_full && !wr_pop) || (ar_hs && rd_full && !rd_pop);
    err_now[ERR_BRESP_ILLEGAL] = BVALID && resp_illegal(BRESP);
    err_now[ERR_RRESP_ILLEGAL] = RVALID && resp_illegal(RRESP);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_status  <= '0;
      err_irq     <= 1'b0;
      wr_done_cnt <= '0;
      rd_done_cnt <= '0;
      pend_b      <= '0;
    end else begin
      err_status <= (err_clr ? '0 : err_status) | err_now;
      err_irq    <= |err_status;
      if (b_hs)          wr_done_cnt <= wr_done_cnt + CNT_WIDTH'(1);
      if (r_hs && RLAST) rd_done_cnt <= rd_done_cnt + CNT_WIDTH'(1);
      case ({w_hs && WLAST, b_hs})
        2'b10:   if (pend_b != '1)   pend_b <= pend_b + 8'd1;
        2'b01:   if (pend_b != 8'd0) pend_b <= pend_b - 8'd1;
        default: pend_b <= pend_b;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Bench for axi4_protocol_monitor: directed scenarios plus randomized multi-burst traffic
// whose expected error bits and completion counts come from per-burst arithmetic.
module tb_axi4_protocol_monitor;
  import axi4_mon_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [9:0]  AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [9:0]  ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        err_clr;
  logic [15:0] err_status;
  logic        err_irq;
  logic [15:0] wr_done_cnt;
  logic [15:0] rd_done_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  always #5 ACLK = ~ACLK;

  axi4_protocol_monitor #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(256), .CNT_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_status(err_status), .err_irq(err_irq),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_bus();
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 0; AWREADY = 0;
    WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; WREADY = 0;
    BRESP = '0; BVALID = 0; BREADY = 0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 0; ARREADY = 0;
    RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0; RREADY = 0;
    err_clr = 0;
  endtask

  task automatic do_reset();
    ARESETn = 0;
    idle_bus();
    tick();
    tick();
    ARESETn = 1;
    exp_wr = 0;
    exp_rd = 0;
  endtask

  task automatic clear_errs();
    err_clr = 1;
    tick();
    err_clr = 0;
    tick();
  endtask

  task automatic aw_xfer(input int addr, input int len, input int size);
    AWADDR = 10'(addr); AWLEN = 8'(len); AWSIZE = 3'(size);
    AWVALID = 1; AWREADY = 1;
    tick();
    AWVALID = 0; AWREADY = 0;
  endtask

  task automatic w_xfer(input logic last);
    WDATA = $urandom; WSTRB = 4'hF; WLAST = last;
    WVALID = 1; WREADY = 1;
    tick();
    WVALID = 0; WREADY = 0; WLAST = 0;
  endtask

  task automatic b_xfer(input logic [1:0] resp);
    BRESP = resp; BVALID = 1; BREADY = 1;
    tick();
    BVALID = 0; BREADY = 0; BRESP = '0;
    exp_wr++;
  endtask

  task automatic ar_xfer(input int addr, input int len, input int size);
    ARADDR = 10'(addr); ARLEN = 8'(len); ARSIZE = 3'(size);
    ARVALID = 1; ARREADY = 1;
    tick();
    ARVALID = 0; ARREADY = 0;
  endtask

  task automatic r_xfer(input logic last, input logic [1:0] resp);
    RDATA = $urandom; RRESP = resp; RLAST = last;
    RVALID = 1; RREADY = 1;
    tick();
    RVALID = 0; RREADY = 0; RLAST = 0; RRESP = '0;
    if (last) exp_rd++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (err_status !== 16'h0) $display("FAIL reset_err_status got=%h exp=0000", err_status); else n_pass++;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL reset_err_irq got=%b exp=0", err_irq); else n_pass++;
    n_checks++; if (wr_done_cnt !== 16'd0) $display("FAIL reset_wr_done got=%0d exp=0", wr_done_cnt); else n_pass++;
    n_checks++; if (rd_done_cnt !== 16'd0) $display("FAIL reset_rd_done got=%0d exp=0", rd_done_cnt); else n_pass++;
  endtask

  task automatic test_write_ok();
    aw_xfer('h10, 3, 2);
    for (int i = 0; i < 4; i++) w_xfer(i == 3);
    b_xfer(RESP_OKAY);
    n_checks++; if (err_status !== 16'h0) $display("FAIL write_ok_err got=%h exp=0000", err_status); else n_pass++;
    n_checks++; if (wr_done_cnt !== 16'(exp_wr)) $display("FAIL write_ok_wr_done got=%0d exp=%0d", wr_done_cnt, exp_wr); else n_pass++;
    tick();
    n_checks++; if (err_irq !== 1'b0) $display("FAIL write_ok_irq got=%b exp=0", err_irq); else n_pass++;
  endtask

  task automatic test_wlast_early();
    logic [15:0] exp_mask;
    exp_mask = '0;
    exp_mask[ERR_W_LAST] = 1'b1;
    aw_xfer('h10, 3, 2);
    w_xfer(0);
    w_xfer(0);
    w_xfer(1);
    n_checks++; if (err_status !== exp_mask) $display("FAIL wlast_err got=%h exp=%h", err_status, exp_mask); else n_pass++;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL wlast_irq_lag got=%b exp=0", err_irq); else n_pass++;
    tick();
    n_checks++; if (err_irq !== 1'b1) $display("FAIL wlast_irq got=%b exp=1", err_irq); else n_pass++;
    b_xfer(RESP_OKAY);
    n_checks++; if (wr_done_cnt !== 16'(exp_wr)) $display("FAIL wlast_wr_done got=%0d exp=%0d", wr_done_cnt, exp_wr); else n_pass++;
    err_clr = 1;
    tick();
    err_clr = 0;
    n_checks++; if (err_status !== 16'h0) $display("FAIL wlast_clr got=%h exp=0000", err_status); else n_pass++;
    tick();
    n_checks++; if (err_irq !== 1'b0) $display("FAIL wlast_irq_clr got=%b exp=0", err_irq); else n_pass++;
  endtask

  task automatic test_ar_stable();
    logic [15:0] exp_mask;
    exp_mask = '0;
    exp_mask[ERR_AR_STABLE] = 1'b1;
    ARADDR = 10'h20; ARLEN = 0; ARSIZE = 2; ARVALID = 1; ARREADY = 0;
    tick();
    n_checks++; if (err_status !== 16'h0) $display("FAIL ar_hold_ok got=%h exp=0000", err_status); else n_pass++;
    ARADDR = 10'h24;
    tick();
    n_checks++; if (err_status !== exp_mask) $display("FAIL ar_stable got=%h exp=%h", err_status, exp_mask); else n_pass++;
    ARREADY = 1;
    tick();
    ARVALID = 0; ARREADY = 0;
    r_xfer(1, RESP_OKAY);
    n_checks++; if (err_status !== exp_mask) $display("FAIL ar_stable_drain got=%h exp=%h", err_status, exp_mask); else n_pass++;
    n_checks++; if (rd_done_cnt !== 16'(exp_rd)) $display("FAIL ar_rd_done got=%0d exp=%0d", rd_done_cnt, exp_rd); else n_pass++;
    clear_errs();
  endtask

  task automatic test_align();
    logic [15:0] exp_mask;
    exp_mask = '0;
    exp_mask[ERR_AW_ALIGN] = 1'b1;
    aw_xfer('h12, 0, 2);
    n_checks++; if (err_status !== exp_mask) $display("FAIL aw_align got=%h exp=%h", err_status, exp_mask); else n_pass++;
    w_xfer(1);
    b_xfer(RESP_OKAY);
    clear_errs();
    ar_xfer('h08, 0, 3);
    n_checks++; if (err_status !== 16'h0) $display("FAIL ar_align_ok got=%h exp=0000", err_status); else n_pass++;
    r_xfer(1, RESP_OKAY);
    n_checks++; if (rd_done_cnt !== 16'(exp_rd)) $display("FAIL align_rd_done got=%0d exp=%0d", rd_done_cnt, exp_rd); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_mask;
    exp_mask = '0;
    exp_mask[ERR_OVERFLOW] = 1'b1;
    ARLEN = 0; ARSIZE = 0; ARVALID = 1; ARREADY = 1;
    for (int i = 0; i < 4; i++) begin
      ARADDR = 10'(i * 4);
      tick();
    end
    n_checks++; if (err_status !== 16'h0) $display("FAIL ovf_at_depth got=%h exp=0000", err_status); else n_pass++;
    ARADDR = 10'h3F0;
    tick();
    ARVALID = 0; ARREADY = 0;
    n_checks++; if (err_status !== exp_mask) $display("FAIL ovf got=%h exp=%h", err_status, exp_mask); else n_pass++;
    for (int i = 0; i < 4; i++) r_xfer(1, RESP_OKAY);
    n_checks++; if (err_status !== exp_mask) $display("FAIL ovf_drain got=%h exp=%h", err_status, exp_mask); else n_pass++;
    n_checks++; if (rd_done_cnt !== 16'(exp_rd)) $display("FAIL ovf_rd_done got=%0d exp=%0d", rd_done_cnt, exp_rd); else n_pass++;
    do_reset();
    exp_mask = '0;
    exp_mask[ERR_R_NO_AR] = 1'b1;
    r_xfer(0, RESP_OKAY);
    n_checks++; if (err_status !== exp_mask) $display("FAIL r_no_ar got=%h exp=%h", err_status, exp_mask); else n_pass++;
    n_checks++; if (rd_done_cnt !== 16'd0) $display("FAIL r_no_ar_cnt got=%0d exp=0", rd_done_cnt); else n_pass++;
    do_reset();
  endtask

  task automatic test_timeout();
    logic [15:0] exp_mask;
    do_reset();
    aw_xfer('h0, 0, 2);
    w_xfer(1);
    b_xfer(RESP_OKAY);
    aw_xfer('h40, 1, 2);
    w_xfer(0);
    AWADDR = 10'h80; AWLEN = 0; AWSIZE = 2; AWVALID = 1; AWREADY = 0;
    repeat (255) tick();
    n_checks++; if (err_status !== 16'h0) $display("FAIL timeout_early got=%h exp=0000", err_status); else n_pass++;
    tick();
    exp_mask = '0;
    exp_mask[ERR_TIMEOUT] = 1'b1;
    n_checks++; if (err_status !== exp_mask) $display("FAIL timeout got=%h exp=%h", err_status, exp_mask); else n_pass++;
    tick();
    n_checks++; if (err_irq !== 1'b1) $display("FAIL timeout_irq got=%b exp=1", err_irq); else n_pass++;
    ARESETn = 0;
    idle_bus();
    tick();
    n_checks++; if (err_status !== 16'h0) $display("FAIL midrst_err got=%h exp=0000", err_status); else n_pass++;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL midrst_irq got=%b exp=0", err_irq); else n_pass++;
    n_checks++; if (wr_done_cnt !== 16'd0) $display("FAIL midrst_wr_done got=%0d exp=0", wr_done_cnt); else n_pass++;
    n_checks++; if (rd_done_cnt !== 16'd0) $display("FAIL midrst_rd_done got=%0d exp=0", rd_done_cnt); else n_pass++;
    ARESETn = 1;
    exp_wr = 0;
    exp_rd = 0;
    w_xfer(1);
    exp_mask = '0;
    exp_mask[ERR_W_NO_AW] = 1'b1;
    n_checks++; if (err_status !== exp_mask) $display("FAIL midrst_queue_flushed got=%h exp=%h", err_status, exp_mask); else n_pass++;
    do_reset();
  endtask

  task automatic test_resp();
    logic [15:0] exp_mask;
    do_reset();
    b_xfer(2'b11);
    exp_mask = '0;
    exp_mask[ERR_B_EARLY] = 1'b1;
    exp_mask[ERR_BRESP_ILLEGAL] = 1'b1;
    n_checks++; if (err_status !== exp_mask) $display("FAIL b_early_resp got=%h exp=%h", err_status, exp_mask); else n_pass++;
    n_checks++; if (wr_done_cnt !== 16'(exp_wr)) $display("FAIL b_early_cnt got=%0d exp=%0d", wr_done_cnt, exp_wr); else n_pass++;
    clear_errs();
    ar_xfer('h100, 0, 2);
    r_xfer(1, 2'b01);
    exp_mask = '0;
    exp_mask[ERR_RRESP_ILLEGAL] = 1'b1;
    n_checks++; if (err_status !== exp_mask) $display("FAIL rresp_illegal got=%h exp=%h", err_status, exp_mask); else n_pass++;
    clear_errs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    AWADDR = 10'h20; AWLEN = 0; AWSIZE = 2; AWVALID = 1; AWREADY = 1;
    WDATA = $urandom; WSTRB = 4'hF; WLAST = 1; WVALID = 1; WREADY = 1;
    tick();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    b_xfer(RESP_OKAY);
    AWADDR = 10'h40; AWLEN = 1; AWVALID = 1; AWREADY = 1;
    WLAST = 0; WVALID = 1; WREADY = 1;
    tick();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
    w_xfer(1);
    b_xfer(RESP_OKAY);
    n_checks++; if (err_status !== 16'h0) $display("FAIL b2b_same_cycle got=%h exp=0000", err_status); else n_pass++;
    for (int i = 0; i < 4; i++) aw_xfer(i * 4, 0, 2);
    AWADDR = 10'h80; AWLEN = 0; AWVALID = 1; AWREADY = 1;
    WLAST = 1; WVALID = 1; WREADY = 1;
    tick();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    n_checks++; if (err_status !== 16'h0) $display("FAIL b2b_full_pushpop got=%h exp=0000", err_status); else n_pass++;
    for (int i = 0; i < 4; i++) w_xfer(1);
    for (int i = 0; i < 5; i++) b_xfer(RESP_SLVERR);
    n_checks++; if (err_status !== 16'h0) $display("FAIL b2b_drain got=%h exp=0000", err_status); else n_pass++;
    n_checks++; if (wr_done_cnt !== 16'(exp_wr)) $display("FAIL b2b_wr_done got=%0d exp=%0d", wr_done_cnt, exp_wr); else n_pass++;
  endtask

  task automatic test_random();
    int nb, addr[4], size[4], len[4], lpos[4];
    int resp;
    logic [15:0] exp_mask;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      nb = $urandom_range(1, 4);
      exp_mask = '0;
      for (int j = 0; j < nb; j++) begin
        addr[j] = $urandom_range(0, 1023);
        size[j] = $urandom_range(0, 2);
        len[j]  = $urandom_range(0, 3);
        lpos[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len[j]) : len[j];
        if (lpos[j] != len[j]) exp_mask[(it % 2) ? ERR_R_LAST : ERR_W_LAST] = 1'b1;
        if ((addr[j] % (1 << size[j])) != 0) exp_mask[(it % 2) ? ERR_AR_ALIGN : ERR_AW_ALIGN] = 1'b1;
      end
      if (it % 2 == 0) begin
        for (int j = 0; j < nb; j++) aw_xfer(addr[j], len[j], size[j]);
        for (int j = 0; j < nb; j++)
          for (int b = 0; b <= lpos[j]; b++) w_xfer(b == lpos[j]);
        for (int j = 0; j < nb; j++) begin
          resp = $urandom_range(0, 3);
          if (resp == 1 || resp == 3) exp_mask[ERR_BRESP_ILLEGAL] = 1'b1;
          b_xfer(2'(resp));
        end
      end else begin
        for (int j = 0; j < nb; j++) ar_xfer(addr[j], len[j], size[j]);
        for (int j = 0; j < nb; j++)
          for (int b = 0; b <= lpos[j]; b++) begin
            resp = $urandom_range(0, 3);
            if (resp == 1 || resp == 3) exp_mask[ERR_RRESP_ILLEGAL] = 1'b1;
            r_xfer(b == lpos[j], 2'(resp));
          end
      end
      n_checks++; if (err_status !== exp_mask) $display("FAIL rand_err it=%0d got=%h exp=%h", it, err_status, exp_mask); else n_pass++;
      n_checks++; if (wr_done_cnt !== 16'(exp_wr) || rd_done_cnt !== 16'(exp_rd))
        $display("FAIL rand_cnt it=%0d got=%0d/%0d exp=%0d/%0d", it, wr_done_cnt, rd_done_cnt, exp_wr, exp_rd);
      else n_pass++;
      clear_errs();
    end
  endtask

  initial begin
    test_reset();
    test_write_ok();
    test_wlast_early();
    test_ar_stable();
    test_align();
    test_overflow();
    test_timeout();
    test_resp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
